// File: rtl/alu_io_pkg.sv
// Shared definitions for the board-level ALU input, ALU and display blocks:
// operand/op widths, ALU op codes and the operand-loader phase encodings.
package alu_io_pkg;

   localparam int DATA_W = 5;
   localparam int OP_W   = 2;

   // ALU operation codes as driven onto ALUControl
   typedef enum logic [OP_W-1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_AND = 2'b10,
      OP_OR  = 2'b11
   } alu_op_e;

   // Operand entry phases; the encoding is shown directly on the phase LEDs
   typedef enum logic [1:0] {
      S_A    = 2'b00,
      S_B    = 2'b01,
      S_OP   = 2'b10,
      S_DONE = 2'b11
   } load_state_e;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stability counter and a
// registered one-cycle pulse on the debounced rising edge only.
// Press-to-pulse latency is 2 + DEBOUNCE_CYCLES + 1 cycles.
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int CNT_W           = 20
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_raw,
   output logic pulse
);

   // Terminal count: the level is accepted on the DEBOUNCE_CYCLES-th stable cycle
   localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             r_sync0;
   logic             r_sync1;
   logic [CNT_W-1:0] r_cnt;
   logic             r_db;
   logic             r_db_d;
   logic             r_pulse;

   // Bring the asynchronous button level into the clock domain
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_sync0 <= 1'b0;
         r_sync1 <= 1'b0;
      end else begin
         r_sync0 <= btn_raw;
         r_sync1 <= r_sync0;
      end
   end

   // Count consecutive cycles where the synchronized level differs from the
   // accepted level; any bounce back to the accepted level restarts the count
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_cnt <= '0;
         r_db  <= 1'b0;
      end else if (r_sync1 == r_db) begin
         r_cnt <= '0;
      end else if (r_cnt == LP_CNT_LAST) begin
         r_db  <= r_sync1;
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   // Registered single-cycle pulse on the accepted 0->1 transition; release is silent
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_db_d  <= 1'b0;
         r_pulse <= 1'b0;
      end else begin
         r_db_d  <= r_db;
         r_pulse <= r_db & ~r_db_d;
      end
   end

   assign pulse = r_pulse;

endmodule

// File: rtl/alu_operand_loader.sv
// Board-level ALU input stage: captures operand a, operand b and the ALU op
// from slide switches in three button-stepped phases and holds them for the ALU.
// Optional build macro LIVE_PREVIEW_EN: the register belonging to the current
// phase follows its switches every cycle until the press freezes it.
module alu_operand_loader
   import alu_io_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int CNT_W           = 20
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] sw,
   input  logic [OP_W-1:0]   op_sw,
   input  logic              btn_next,
   input  logic              btn_clear,
   output logic [DATA_W-1:0] a,
   output logic [DATA_W-1:0] b,
   output logic [OP_W-1:0]   ALUControl,
   output logic              valid,
   output logic [1:0]        phase
);

   // Bit 0 = next, bit 1 = clear
   logic [1:0] w_btn_raw;
   logic [1:0] w_btn_pulse;
   logic       w_next_pulse;
   logic       w_clear_pulse;

   assign w_btn_raw = {btn_clear, btn_next};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_btn
         btn_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
         ) u_btn_debounce (
            .clk     (clk),
            .reset   (reset),
            .btn_raw (w_btn_raw[gi]),
            .pulse   (w_btn_pulse[gi])
         );
      end
   endgenerate

   assign w_next_pulse  = w_btn_pulse[0];
   assign w_clear_pulse = w_btn_pulse[1];

   load_state_e       r_state;
   load_state_e       w_state_next;
   logic [DATA_W-1:0] r_a;
   logic [DATA_W-1:0] w_a_next;
   logic [DATA_W-1:0] r_b;
   logic [DATA_W-1:0] w_b_next;
   logic [OP_W-1:0]   r_op;
   logic [OP_W-1:0]   w_op_next;
   logic              r_valid;
   logic              w_valid_next;

   // State and operand registers
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= S_A;
         r_a     <= '0;
         r_b     <= '0;
         r_op    <= OP_ADD;
         r_valid <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_a     <= w_a_next;
         r_b     <= w_b_next;
         r_op    <= w_op_next;
         r_valid <= w_valid_next;
      end
   end

   // Phase sequencing and operand capture; clear overrides a coincident next press
   always_comb begin
      w_state_next = r_state;
      w_a_next     = r_a;
      w_b_next     = r_b;
      w_op_next    = r_op;
      w_valid_next = r_valid;

      if (w_clear_pulse) begin
         w_state_next = S_A;
         w_valid_next = 1'b0;
      end else begin
         case (r_state)
            S_A: begin
`ifdef LIVE_PREVIEW_EN
               w_a_next = sw;
`endif
               if (w_next_pulse) begin
                  w_a_next     = sw;
                  w_state_next = S_B;
               end
            end
            S_B: begin
`ifdef LIVE_PREVIEW_EN
               w_b_next = sw;
`endif
               if (w_next_pulse) begin
                  w_b_next     = sw;
                  w_state_next = S_OP;
               end
            end
            S_OP: begin
`ifdef LIVE_PREVIEW_EN
               w_op_next = op_sw;
`endif
               if (w_next_pulse) begin
                  w_op_next    = op_sw;
                  w_valid_next = 1'b1;
                  w_state_next = S_DONE;
               end
            end
            S_DONE: begin
               if (w_next_pulse) begin
                  w_valid_next = 1'b0;
                  w_state_next = S_A;
               end
            end
            default: begin
               w_state_next = S_A;
               w_valid_next = 1'b0;
            end
         endcase
      end
   end

   assign a          = r_a;
   assign b          = r_b;
   assign ALUControl = r_op;
   assign valid      = r_valid;
   assign phase      = r_state;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Directed bench for alu_operand_loader with a short debounce window (4 cycles).
// Honors LIVE_PREVIEW_EN the same way as the design build.
module tb_alu_operand_loader;

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] sw;
   logic [1:0] op_sw;
   logic       btn_next;
   logic       btn_clear;
   logic [4:0] a;
   logic [4:0] b;
   logic [1:0] ALUControl;
   logic       valid;
   logic [1:0] phase;

   int n_checks = 0;
   int n_fail   = 0;
   int lat;

`ifdef LIVE_PREVIEW_EN
   localparam bit LIVE = 1'b1;
`else
   localparam bit LIVE = 1'b0;
`endif

   alu_operand_loader #(
      .DEBOUNCE_CYCLES (4),
      .CNT_W           (3)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .sw         (sw),
      .op_sw      (op_sw),
      .btn_next   (btn_next),
      .btn_clear  (btn_clear),
      .a          (a),
      .b          (b),
      .ALUControl (ALUControl),
      .valid      (valid),
      .phase      (phase)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Advance n cycles; returns 1 time unit after the last rising edge
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Optional 1-cycle bounces, then a final rise held for 20 cycles; reports the
   // number of edges until phase moves (-1 if it never does), then releases.
   task automatic press(input bit nxt, input bit clr, input int bounces, output int latency);
      logic [1:0] ph0;
      for (int i = 0; i < bounces; i++) begin
         btn_next = nxt; btn_clear = clr;
         tick(1);
         btn_next = 1'b0; btn_clear = 1'b0;
         tick(1);
      end
      ph0 = phase;
      latency = -1;
      btn_next = nxt; btn_clear = clr;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk);
         #1;
         if (phase != ph0 && latency < 0) latency = k;
      end
      btn_next = 1'b0; btn_clear = 1'b0;
      tick(12);
      $display("press next=%0b clear=%0b bounces=%0d: latency=%0d phase=%0b a=%b b=%b op=%b valid=%0b",
               nxt, clr, bounces, latency, phase, a, b, ALUControl, valid);
   endtask

   initial begin
      reset = 1'b0; sw = '0; op_sw = '0; btn_next = 1'b0; btn_clear = 1'b0;
      @(posedge clk);
      #1;

      // 1: reset state
      tick(2);
      check_eq("rst_a", a, 0);
      check_eq("rst_b", b, 0);
      check_eq("rst_op", ALUControl, 0);
      check_eq("rst_valid", valid, 0);
      check_eq("rst_phase", phase, 0);
      reset = 1'b1;
      tick(1);

      // 6: live preview of a in S_A (registers stay put without the feature)
      sw = 5'b00001;
      tick(1);
      check_eq("preview_a1", a, LIVE ? 32'h01 : 32'h00);
      sw = 5'b10101;
      tick(1);
      check_eq("preview_a2", a, LIVE ? 32'h15 : 32'h00);

      // 2: three-phase load
      sw = 5'b00011;
      press(1'b1, 1'b0, 0, lat);
      check_eq("load_a_lat", lat, 8);
      check_eq("load_a_phase", phase, 2'b01);
      check_eq("load_a", a, 5'b00011);
      sw = 5'b11110;
      press(1'b1, 1'b0, 0, lat);
      check_eq("load_b_phase", phase, 2'b10);
      check_eq("load_b", b, 5'b11110);
      check_eq("load_b_valid", valid, 0);
      op_sw = 2'b01;
      press(1'b1, 1'b0, 0, lat);
      check_eq("load_op_phase", phase, 2'b11);
      check_eq("load_op", ALUControl, 2'b01);
      check_eq("load_op_valid", valid, 1);
      check_eq("load_op_a", a, 5'b00011);
      check_eq("load_op_b", b, 5'b11110);

      // 3: bouncy press from S_DONE -> one step back to S_A, 8 edges after final rise
      press(1'b1, 1'b0, 2, lat);
      check_eq("bounce_lat", lat, 8);
      check_eq("bounce_phase", phase, 2'b00);
      check_eq("bounce_valid", valid, 0);
      check_eq("bounce_b_kept", b, 5'b11110);

      // 4: clear and next together in S_OP -> clear wins
      sw = 5'b01010;
      press(1'b1, 1'b0, 0, lat);
      sw = 5'b00111;
      press(1'b1, 1'b0, 0, lat);
      check_eq("pre_clr_phase", phase, 2'b10);
      op_sw = 2'b10;
      tick(2);
      press(1'b1, 1'b1, 0, lat);
      check_eq("clr_lat", lat, 8);
      check_eq("clr_phase", phase, 2'b00);
      check_eq("clr_valid", valid, 0);
      check_eq("clr_op", ALUControl, LIVE ? 32'h2 : 32'h1);
      check_eq("clr_b", b, 5'b00111);
      check_eq("clr_a", a, LIVE ? 32'h07 : 32'h0A);

      // 5a: long hold -> single step
      sw = 5'b10000;
      btn_next = 1'b1;
      tick(50);
      check_eq("hold_phase", phase, 2'b01);
      btn_next = 1'b0;
      tick(12);
      check_eq("hold_phase_rel", phase, 2'b01);
      check_eq("hold_a", a, 5'b10000);
      $display("hold 50 cycles: phase=%0b a=%b", phase, a);

      // 5b: reset during debounce discards the pending press
      btn_next = 1'b1;
      tick(3);
      reset = 1'b0;
      btn_next = 1'b0;
      tick(2);
      reset = 1'b1;
      tick(20);
      check_eq("rst_mid_phase", phase, 2'b00);
      check_eq("rst_mid_valid", valid, 0);
      check_eq("rst_mid_a", a, LIVE ? 32'h10 : 32'h00);
      $display("reset mid-debounce: phase=%0b a=%b valid=%0b", phase, a, valid);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
